// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
// Holds the default divisor width, the half-period helper and the
// per-channel rule priority (stop > start/sync > wrap > step).
// Optional feature macro: CLK_DIV_MULTI_SYNC_EN (global phase restart).
package clk_div_pkg;

   localparam int DIV_W_DEF = 16;

   // Channel run state: idle until enabled, then running.
   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } chan_state_t;

   // Which update a channel takes on an edge.
   typedef enum logic [1:0] {
      RULE_STOP  = 2'd0,
      RULE_START = 2'd1,
      RULE_WRAP  = 2'd2,
      RULE_STEP  = 2'd3
   } chan_rule_t;

   // High time of one period: ceil((shadow+1)/2) = (shadow+2)>>1.
   // Computed one bit wider so shadow = all-ones does not overflow.
   function automatic logic [32:0] half_period(input logic [31:0] shadow);
      return ({1'b0, shadow} + 33'd2) >> 1;
   endfunction

   // Rule priority: a disabled channel always stops; a sync request
   // restarts like a fresh enable and beats both wrap and increment.
   function automatic chan_rule_t chan_rule(input logic en,
                                            input logic running,
                                            input logic at_wrap,
                                            input logic sync);
      if (!en)                return RULE_STOP;
      if (!running || sync)   return RULE_START;
      if (at_wrap)            return RULE_WRAP;
      return RULE_STEP;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadowed divisor, level and tick outputs.
// The divisor is only sampled into the shadow when the channel is stopped,
// starts, or wraps, so period changes never produce a runt pulse.
// With CLK_DIV_MULTI_SYNC_EN defined a sync input restarts the phase.
// Supports DIV_W up to 32.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
)(
   input  logic             clk_fsys,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic             sync,
`endif
   output logic             out,
   output logic             tick,
   output logic             pending
);

   chan_state_t      state_q, state_d;
   chan_rule_t       rule;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;
   logic             sync_req;
   logic [32:0]      cnt_inc_w;
   logic [32:0]      half_w;

`ifdef CLK_DIV_MULTI_SYNC_EN
   assign sync_req = sync;
`else
   assign sync_req = 1'b0;
`endif

   assign cnt_inc_w = 33'(cnt_q) + 33'd1;
   assign half_w    = half_period(32'(shadow_q));
   assign rule      = chan_rule(en, state_q == CH_RUN, cnt_q == shadow_q, sync_req);

   // State registers; reset clears everything regardless of phase.
   always_ff @(posedge clk_fsys or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= CH_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         out_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         tick_q   <= tick_d;
      end
   end

   // Next-state: apply the rule selected for this edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      tick_d   = tick_q;
      case (rule)
         RULE_STOP: begin
            state_d  = CH_IDLE;
            cnt_d    = '0;
            shadow_d = div;
            out_d    = 1'b0;
            tick_d   = 1'b0;
         end
         RULE_START, RULE_WRAP: begin
            state_d  = CH_RUN;
            cnt_d    = '0;
            shadow_d = div;
            out_d    = 1'b1;
            tick_d   = 1'b1;
         end
         default: begin
            cnt_d    = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            out_d    = (cnt_inc_w < half_w);
            tick_d   = 1'b0;
         end
      endcase
   end

   assign out     = out_q;
   assign tick    = tick_q;
   assign pending = (div != shadow_q);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator. Each channel divides
// the system clock by (D_i + 1) and provides a ~50% level and a 1-cycle tick.
// Optional feature macro: CLK_DIV_MULTI_SYNC_EN adds clk_div_multi_sync,
// which restarts the phase of every enabled channel at once.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DIV_W = DIV_W_DEF
)(
   input  logic                 clk_div_multi_fsys,
   input  logic                 clk_div_multi_rst_n,
   input  logic [NCH-1:0]       clk_div_multi_en,
   input  logic [NCH*DIV_W-1:0] clk_div_multi_div,
`ifdef CLK_DIV_MULTI_SYNC_EN
   input  logic                 clk_div_multi_sync,
`endif
   output logic [NCH-1:0]       clk_div_multi_out,
   output logic [NCH-1:0]       clk_div_multi_tick,
   output logic [NCH-1:0]       clk_div_multi_pending
);

   // One independent channel per slice of the divisor bus.
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      clk_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk_fsys (clk_div_multi_fsys),
         .rst_n    (clk_div_multi_rst_n),
         .en       (clk_div_multi_en[i]),
         .div      (clk_div_multi_div[i*DIV_W +: DIV_W]),
`ifdef CLK_DIV_MULTI_SYNC_EN
         .sync     (clk_div_multi_sync),
`endif
         .out      (clk_div_multi_out[i]),
         .tick     (clk_div_multi_tick[i]),
         .pending  (clk_div_multi_pending[i])
      );
   end

endmodule
